// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART challenge receiver.
//   BYTE_W               : bits per UART character
//   BIT_IDX_W            : width of the within-byte bit index
//   DEFAULT_CLKS_PER_BIT : 100 MHz system clock / 115200 baud
//   S_* / rx_state_e     : bit-level FSM state encoding
//   even_parity()        : parity bit that makes the 9-bit group even
// Optional feature macro: UART_RX_PARITY_EN (enables the PARITY state).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned BYTE_W               = 8;
    localparam int unsigned BIT_IDX_W            = $clog2(BYTE_W);
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } rx_state_e;

    function automatic logic even_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// Bit-level UART receiver: synchronises rx, finds the start bit, samples eight
// data bits LSB first at mid-bit, checks the stop bit (and, with
// UART_RX_PARITY_EN defined, an even parity bit before it).
// Ports:
//   clk_i, rst_ni   : system clock, asynchronous active-low reset
//   rx_i            : raw serial input, idle high, asynchronous to clk_i
//   enable_i        : gates acceptance of new start bits only
//   byte_o          : received byte (valid while byte_valid_o is high)
//   byte_valid_o    : one-cycle pulse, good stop bit sampled
//   byte_err_o      : one-cycle pulse, bad stop bit or bad parity
//   start_seen_o    : one-cycle pulse, start bit confirmed at mid-bit
//
// state  | meaning
// IDLE   | waiting for rxs low while enabled
// START  | half-bit wait, then confirm start bit (high = glitch)
// DATA   | eight mid-bit samples, LSB first
// PARITY | one mid-bit even-parity sample (UART_RX_PARITY_EN only)
// STOP   | one mid-bit stop sample, then straight back to IDLE
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              enable_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    output logic              byte_err_o,
    output logic              start_seen_o
);

    localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(BYTE_W - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]   bit_q, bit_d;
    logic [BYTE_W-1:0]      shift_q, shift_d;

    // Synchroniser flops reset to the idle (high) level so reset never looks
    // like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // The down-counter is reloaded on every state change, so it never wraps.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        byte_err_o   = 1'b0;
        start_seen_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs && enable_i) begin
                    state_d = ST_START;
                    cnt_d   = HALF_M1;
                end
            end

            ST_START: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Reported only once the start bit is confirmed, so a
                        // glitch has no effect outside this module.
                        state_d      = ST_DATA;
                        cnt_d        = BIT_M1;
                        bit_d        = '0;
                        start_seen_o = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs, shift_q[BYTE_W-1:1]};
                    cnt_d   = BIT_M1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    if (rxs != even_parity(shift_q)) begin
                        byte_err_o = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_STOP;
                        cnt_d   = BIT_M1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif

            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is caught
                // without waiting for the end of the stop bit.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (rxs) begin
                        byte_valid_o = 1'b1;
                    end else begin
                        byte_err_o = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/uart_rx_word16.sv
// -----------------------------------------------------------------------------
// uart_rx_word16
// Receives two UART bytes and assembles a 16-bit challenge word, low byte
// first, for the binary-to-Gray stage and the PUF core.
// Parameters:
//   CLKS_PER_BIT : clk cycles per UART bit (>= 8)
//   SYNC_STAGES  : rx synchroniser depth (>= 2)
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   rx         : UART serial input, idle high, asynchronous
//   enable     : blocks new start bits when low; a byte in flight completes
//   data       : assembled word {byte1, byte0}, stable until the next word
//   done       : level, set with data, cleared when byte 0 of the next word
//                starts
//   frame_err  : one-cycle pulse on a bad stop bit (or bad parity)
// Optional feature macro: UART_RX_PARITY_EN (8E1 instead of 8N1).
// -----------------------------------------------------------------------------
module uart_rx_word16
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx,
    input  logic                enable,
    output logic [2*BYTE_W-1:0] data,
    output logic                done,
    output logic                frame_err
);

    logic [BYTE_W-1:0]   rx_byte;
    logic                byte_valid;
    logic                byte_err;
    logic                start_seen;

    logic                idx_q, idx_d;
    logic [BYTE_W-1:0]   shadow_q, shadow_d;
    logic [2*BYTE_W-1:0] data_q, data_d;
    logic                done_q, done_d;
    logic                ferr_q, ferr_d;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx_byte (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_i         (rx),
        .enable_i     (enable),
        .byte_o       (rx_byte),
        .byte_valid_o (byte_valid),
        .byte_err_o   (byte_err),
        .start_seen_o (start_seen)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= 1'b0;
            shadow_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        idx_d    = idx_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        done_d   = done_q;
        ferr_d   = byte_err;

        // done stays up across the gap so slower-clocked consumers see it.
        if (start_seen && !idx_q) begin
            done_d = 1'b0;
        end

        if (byte_valid) begin
            if (!idx_q) begin
                shadow_d = rx_byte;
                idx_d    = 1'b1;
            end else begin
                data_d = {rx_byte, shadow_q};
                done_d = 1'b1;
                idx_d  = 1'b0;
            end
        end

        // A bad frame realigns the word: the pending low byte is dropped.
        if (byte_err) begin
            idx_d    = 1'b0;
            shadow_d = '0;
        end
    end

    assign data      = data_q;
    assign done      = done_q;
    assign frame_err = ferr_q;

endmodule
